// File: rtl/interrupt_controller.sv
// Priority interrupt controller: NUM_PHER level requests arbitrated by a
// software-programmed priority per line, one grant held until serviced.
// Optional feature macro: INTRP_MASK_EN adds a MASK register at addr NUM_PHER.
module interrupt_controller #(
  parameter int unsigned NUM_PHER   = 16,
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sel,
  input  logic                  enable,
  input  logic                  write,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [WIDTH-1:0]      wdata,
  output logic [WIDTH-1:0]      rdata,
  output logic                  ready,
  output logic                  error,
  input  logic [NUM_PHER-1:0]   int_valid,
  output logic                  intrp_valid,
  output logic [NUM_PHER-1:0]   pher_with_intrp,
  input  logic                  intrp_serviced
);

  localparam int unsigned IdxW = (NUM_PHER > 1) ? $clog2(NUM_PHER) : 1;

  typedef enum logic [1:0] {StIdle, StArb, StService} state_e;

  state_e state_q, state_d;

  logic [IdxW-1:0]     pri_q [NUM_PHER];
  logic [NUM_PHER-1:0] mask;
  logic [NUM_PHER-1:0] req;

  logic access;
  logic addr_is_pri;
  logic addr_is_mask;
  logic wdata_ok;
  logic pri_we;
  logic [IdxW-1:0] pri_idx;

  logic            win_found;
  logic [IdxW-1:0] win_pri;
  logic [IdxW-1:0] win_idx;
  logic            grant_load;
  logic            grant_clear;

  logic                intrp_valid_q;
  logic [NUM_PHER-1:0] pher_q;

  assign access      = sel & enable;
  assign ready       = access;
  assign addr_is_pri = (addr < ADDR_WIDTH'(NUM_PHER));
  assign wdata_ok    = (wdata < WIDTH'(NUM_PHER));
  assign pri_idx     = addr[IdxW-1:0];
  assign pri_we      = access & write & addr_is_pri & wdata_ok;

`ifdef INTRP_MASK_EN
  logic mask_we;
  logic [NUM_PHER-1:0] mask_q;

  assign addr_is_mask = (addr == ADDR_WIDTH'(NUM_PHER));
  assign mask_we      = access & write & addr_is_mask;
  assign mask         = mask_q;

  // Mask register; any write data is accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mask_q <= '0;
    end else if (mask_we) begin
      mask_q <= wdata[NUM_PHER-1:0];
    end
  end
`else
  assign addr_is_mask = 1'b0;
  assign mask         = '0;
`endif

  assign req = int_valid & ~mask;

  // Access decode: reject unmapped addresses and out-of-range priorities.
  always_comb begin
    error = 1'b0;
    if (access) begin
      if (addr_is_pri) begin
        error = write & ~wdata_ok;
      end else if (!addr_is_mask) begin
        error = 1'b1;
      end
    end
  end

  // Read mux; zero whenever no clean read is in progress.
  always_comb begin
    rdata = '0;
    if (access && !write && !error) begin
      if (addr_is_pri) begin
        rdata = WIDTH'(pri_q[pri_idx]);
      end else if (addr_is_mask) begin
        rdata = WIDTH'(mask);
      end
    end
  end

  // Priority registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_PHER; i++) begin
        pri_q[i] <= '0;
      end
    end else if (pri_we) begin
      pri_q[pri_idx] <= wdata[IdxW-1:0];
    end
  end

  // Arbiter: strict greater-than keeps the lowest index on a tie.
  always_comb begin
    win_found = 1'b0;
    win_pri   = '0;
    win_idx   = '0;
    for (int i = 0; i < NUM_PHER; i++) begin
      if (req[i] && (!win_found || (pri_q[i] > win_pri))) begin
        win_found = 1'b1;
        win_pri   = pri_q[i];
        win_idx   = IdxW'(i);
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state and grant control.
  always_comb begin
    state_d     = state_q;
    grant_load  = 1'b0;
    grant_clear = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (|req) begin
          state_d = StArb;
        end
      end
      StArb: begin
        // Requests may have vanished since IDLE; fall back without a grant.
        if (win_found) begin
          grant_load = 1'b1;
          state_d    = StService;
        end else begin
          state_d = StIdle;
        end
      end
      StService: begin
        if (intrp_serviced) begin
          grant_clear = 1'b1;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Grant registers, held stable for the whole service window.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      intrp_valid_q <= 1'b0;
      pher_q        <= '0;
    end else if (grant_load) begin
      intrp_valid_q <= 1'b1;
      pher_q        <= NUM_PHER'(win_idx);
    end else if (grant_clear) begin
      intrp_valid_q <= 1'b0;
    end
  end

  assign intrp_valid     = intrp_valid_q;
  assign pher_with_intrp = pher_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed self-checking bench for interrupt_controller (default build, no mask).
module tb_interrupt_controller;

  logic        clk;
  logic        rst;
  logic        sel;
  logic        enable;
  logic        write;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        ready;
  logic        error;
  logic [15:0] int_valid;
  logic        intrp_valid;
  logic [15:0] pher_with_intrp;
  logic        intrp_serviced;

  int n_checks;
  int n_fail;

  interrupt_controller #(
    .NUM_PHER  (16),
    .WIDTH     (16),
    .ADDR_WIDTH(16)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .sel            (sel),
    .enable         (enable),
    .write          (write),
    .addr           (addr),
    .wdata          (wdata),
    .rdata          (rdata),
    .ready          (ready),
    .error          (error),
    .int_valid      (int_valid),
    .intrp_valid    (intrp_valid),
    .pher_with_intrp(pher_with_intrp),
    .intrp_serviced (intrp_serviced)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic reg_write(input logic [15:0] a, input logic [15:0] d, input logic exp_err);
    @(negedge clk);
    sel = 1'b1; enable = 1'b1; write = 1'b1; addr = a; wdata = d;
    #1;
    check_eq("wr_ready", 32'(ready), 32'd1);
    check_eq("wr_error", 32'(error), 32'(exp_err));
    @(negedge clk);
    sel = 1'b0; enable = 1'b0; write = 1'b0;
  endtask

  task automatic reg_read(input logic [15:0] a, input logic [15:0] exp_d, input logic exp_err);
    @(negedge clk);
    sel = 1'b1; enable = 1'b1; write = 1'b0; addr = a;
    #1;
    check_eq("rd_ready", 32'(ready), 32'd1);
    check_eq("rd_error", 32'(error), 32'(exp_err));
    check_eq("rd_data", 32'(rdata), 32'(exp_d));
    @(negedge clk);
    sel = 1'b0; enable = 1'b0;
  endtask

  // Raise requests and check the two-edge grant latency.
  task automatic request(input logic [15:0] v, input int exp_idx);
    @(negedge clk);
    int_valid = v;
    @(negedge clk);
    check_eq("lat_arb_valid", 32'(intrp_valid), 32'd0);
    @(negedge clk);
    check_eq("grant_valid", 32'(intrp_valid), 32'd1);
    check_eq("grant_idx", 32'(pher_with_intrp), 32'(exp_idx));
  endtask

  // Service the current grant while dropping its line, then check the next grant.
  task automatic serve(input int drop, input int exp_idx, input logic has_next);
    @(negedge clk);
    intrp_serviced = 1'b1;
    int_valid[drop] = 1'b0;
    @(negedge clk);
    intrp_serviced = 1'b0;
    check_eq("svc_clear", 32'(intrp_valid), 32'd0);
    @(negedge clk);
    check_eq("svc_gap", 32'(intrp_valid), 32'd0);
    @(negedge clk);
    check_eq("next_valid", 32'(intrp_valid), 32'(has_next));
    if (has_next) check_eq("next_idx", 32'(pher_with_intrp), 32'(exp_idx));
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    rst = 1'b0;
    sel = 1'b0; enable = 1'b0; write = 1'b0; addr = '0; wdata = '0;
    int_valid = '0;
    intrp_serviced = 1'b0;

    repeat (2) @(negedge clk);
    check_eq("rst_valid", 32'(intrp_valid), 32'd0);
    check_eq("rst_idx", 32'(pher_with_intrp), 32'd0);
    check_eq("rst_ready", 32'(ready), 32'd0);
    check_eq("rst_error", 32'(error), 32'd0);
    check_eq("rst_rdata", 32'(rdata), 32'd0);
    rst = 1'b1;

    // Ascending priorities: grants 15 down to 0.
    for (int i = 0; i < 16; i++) reg_write(16'(i), 16'(i), 1'b0);
    for (int i = 0; i < 16; i++) reg_read(16'(i), 16'(i), 1'b0);
    request(16'hFFFF, 15);
    for (int k = 15; k >= 1; k--) serve(k, k - 1, 1'b1);
    serve(0, 0, 1'b0);

    // Descending priorities: grants 0 up to 15.
    for (int i = 0; i < 16; i++) reg_write(16'(i), 16'(15 - i), 1'b0);
    request(16'hFFFF, 0);
    for (int k = 0; k <= 14; k++) serve(k, k + 1, 1'b1);
    serve(15, 0, 1'b0);

    // Rejected accesses leave state untouched.
    reg_write(16'd16, 16'd5, 1'b1);
    reg_write(16'h0100, 16'd1, 1'b1);
    reg_read(16'd16, 16'd0, 1'b1);
    reg_write(16'd3, 16'd16, 1'b1);
    reg_read(16'd3, 16'd12, 1'b0);
    reg_read(16'd15, 16'd0, 1'b0);

    // Request dropped while in ARB: no grant.
    @(negedge clk);
    int_valid = 16'h0001;
    @(negedge clk);
    int_valid = 16'h0000;
    @(negedge clk);
    check_eq("arb_drop_valid", 32'(intrp_valid), 32'd0);
    @(negedge clk);
    check_eq("arb_drop_idle", 32'(intrp_valid), 32'd0);

    // Tie on equal priorities; grant held through new requests and writes.
    for (int i = 0; i < 16; i++) reg_write(16'(i), 16'd0, 1'b0);
    request(16'h0024, 2);
    int_valid[0] = 1'b1;
    reg_write(16'd0, 16'd9, 1'b0);
    repeat (2) @(negedge clk);
    check_eq("hold_valid", 32'(intrp_valid), 32'd1);
    check_eq("hold_idx", 32'(pher_with_intrp), 32'd2);
    serve(2, 0, 1'b1);
    serve(0, 5, 1'b1);
    serve(5, 0, 1'b0);

    // Asynchronous reset during SERVICE.
    request(16'h0002, 1);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_eq("async_rst_valid", 32'(intrp_valid), 32'd0);
    check_eq("async_rst_idx", 32'(pher_with_intrp), 32'd0);
    int_valid = '0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 16; i++) reg_read(16'(i), 16'd0, 1'b0);
    @(negedge clk);
    check_eq("post_rst_idle", 32'(intrp_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
